// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchronisers, frame FSM with inactivity timeout, show-ahead scan-code FIFO.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_kbd_rx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BW = 3;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    logic [2:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    state_e        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [8:0]    frame_q, frame_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          frame_err_q, overflow_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic fall_c, data_s_c, frame_ok_c, push_c, err_c;
    logic pop_c, full_c, empty_c, wr_en_c;

    // Pin synchronisers; idle-high lines so they reset to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign fall_c   = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_s_c = data_sync_q[1];

    // Data and parity share one 9-bit LSB-first shifter: byte in [7:0], parity in [8].
`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok_c = data_s_c & (^frame_q);
`else
    assign frame_ok_c = data_s_c;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            to_cnt_q    <= to_cnt_d;
            frame_err_q <= err_c;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        to_cnt_d  = (state_q == IDLE) ? '0 : TW'(to_cnt_q + 1'b1);
        push_c    = 1'b0;
        err_c     = 1'b0;
        if (fall_c) begin
            to_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_s_c) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    frame_d   = {data_s_c, frame_q[8:1]};
                    bit_cnt_d = BW'(bit_cnt_q + 1'b1);
                    if (bit_cnt_q == BW'(7)) state_d = PARITY;
                end
                PARITY: begin
                    frame_d = {data_s_c, frame_q[8:1]};
                    state_d = STOP;
                end
                STOP: begin
                    push_c  = frame_ok_c;
                    err_c   = ~frame_ok_c;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && to_cnt_q == TW'(TIMEOUT_CYC)) begin
            state_d  = IDLE;
            err_c    = 1'b1;
            to_cnt_d = '0;
        end
    end

    // Show-ahead FIFO; a push into a full FIFO only lands when a pop frees the slot.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c   = rx_valid & rx_ready;
    assign wr_en_c = push_c & (~full_c | pop_c);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr_q <= PW'(wr_ptr_q + 1'b1);
            if (pop_c)   rd_ptr_q <= PW'(rd_ptr_q + 1'b1);
            if (push_c & full_c & ~pop_c) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= frame_q[7:0];
    end

    assign rx_valid  = ~empty_c;
    assign rx_data   = rx_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
